// File: rtl/mod100_counter_pkg.sv
// Shared constants for the centi-tick timebase counter.
// The count width is derived from the modulus so that the two stay consistent.
package mod100_counter_pkg;

  localparam int MODULUS_DEFAULT = 100;

  function automatic int count_width(input int modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction

  localparam int WIDTH_DEFAULT = count_width(MODULUS_DEFAULT);

endpackage

// File: rtl/mod100_counter_chk.sv
// Property checker for the modulo counter: held at zero in reset,
// legal values step by one or wrap, and out-of-range values fall back to zero.
module mod100_counter_chk #(
  parameter int MODULUS = 100,
  parameter int WIDTH   = 7
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] LP_ZERO = {WIDTH{1'b0}};

  a_reset_zero: assert property (@(posedge clk) !rst |-> count == LP_ZERO);

  a_step: assert property (@(posedge clk) disable iff (!rst)
    (count < LP_MAX) |=> (count == $past(count) + LP_ONE));

  // Covers both the terminal value and any upset value above it.
  a_wrap: assert property (@(posedge clk) disable iff (!rst)
    (count >= LP_MAX) |=> (count == LP_ZERO));

endmodule

// File: rtl/mod100_counter.sv
// Free-running modulo-MODULUS up-counter (default 0..99) used as a centi-tick
// timebase; asynchronous active-low reset, count is a direct register output.
module mod100_counter
  import mod100_counter_pkg::*;
#(
  parameter int MODULUS = MODULUS_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  if (MODULUS < 2) begin : g_bad_modulus
    $error("mod100_counter: MODULUS must be at least 2");
  end
  if ((WIDTH < 1) || (WIDTH > 31) || ((64'd1 << WIDTH) < 64'(MODULUS))) begin : g_bad_width
    $error("mod100_counter: WIDTH too small to hold MODULUS-1");
  end

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] LP_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;

  // Anything at or above the terminal value (including upset states) returns to zero.
  always_comb begin
    w_count_next = LP_ZERO;
    if (r_count < LP_MAX) begin
      w_count_next = r_count + LP_ONE;
    end else begin
      w_count_next = LP_ZERO;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= LP_ZERO;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;

  mod100_counter_chk #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .count (r_count)
  );

endmodule

// File: tb/tb_mod100_counter.sv
// Scoreboard bench for mod100_counter: default instance plus a MODULUS=10 variant.
module tb_mod100_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst10;
  logic [6:0] count;
  logic [3:0] count10;

  typedef struct {
    int    t;
    bit    sel;
    int    val;
    string tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mod100_counter u_dut (
    .clk   (clk),
    .rst   (rst),
    .count (count)
  );

  mod100_counter #(.MODULUS(10), .WIDTH(4)) u_dut10 (
    .clk   (clk),
    .rst   (rst10),
    .count (count10)
  );

  task automatic push(input int t, input bit sel, input int val, input string tag);
    exp_t e;
    e.t = t;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic check_slot();
    exp_t e;
    int   act;
    while (q.size() > 0 && q[0].t <= int'($time)) begin
      e = q.pop_front();
      act = e.sel ? int'(count10) : int'(count);
      checks++;
      if (e.t != int'($time)) begin
        errors++;
        $display("FAIL %s t=%0d: sample slot missed at t=%0d", e.tag, e.t, $time);
      end else if (act != e.val) begin
        errors++;
        $display("FAIL %s t=%0d: count=%0d expected=%0d", e.tag, e.t, act, e.val);
      end
    end
  endtask

  // Two sample slots per cycle: 2 after the edge, and mid-cycle after rst changes.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check_slot();
      checks++;
      if (count > 7'd99 || count10 > 4'd9) begin
        errors++;
        $display("FAIL range t=%0d: count=%0d count10=%0d", $time, count, count10);
      end
      #5;
      check_slot();
    end
  end

  initial begin
    rst = 1'b0;
    rst10 = 1'b0;
    push(7, 1'b0, 0, "por_hold");
    #10;
    rst = 1'b1;
    for (int k = 1; k <= 21; k++) push(10 * k + 7, 1'b0, k, "count");
    #210;
    rst = 1'b0;
    push(222, 1'b0, 0, "async_rst");
    push(227, 1'b0, 0, "rst_hold");
    #10;
    rst = 1'b1;
    for (int k = 23; k <= 123; k++) push(10 * k + 7, 1'b0, (k - 22) % 100, (k >= 122) ? "wrap" : "recount");
    #1020;
    push(1257, 1'b1, 0, "v_rst_hold");
    #10;
    rst10 = 1'b1;
    for (int k = 126; k <= 137; k++) push(10 * k + 7, 1'b1, (k - 125) % 10, "v_count");
    #120;
    rst10 = 1'b0;
    push(1382, 1'b1, 0, "v_async_rst");
    push(1387, 1'b1, 0, "v_rst_hold2");
    #10;
    rst10 = 1'b1;
    force u_dut10.r_count = 4'd12;
    #1;
    release u_dut10.r_count;
    push(1392, 1'b1, 12, "v_forced");
    push(1397, 1'b1, 0, "v_illegal");
    push(1407, 1'b1, 1, "v_restart1");
    push(1417, 1'b1, 2, "v_restart2");
    #40;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
